// File: rtl/sb_burst_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sb_burst_master_pkg
//  Description : Shared types and constants for the system-bus burst master:
//                FSM state encoding, bus field widths, byte-enable pattern.
//  Revision    : 1.0  initial release
// ============================================================================
package sb_burst_master_pkg;

    localparam int c_SB_ADDR_W = 32;
    localparam int c_SB_DATA_W = 32;
    localparam int c_SB_BE_W   = 4;
    localparam int c_SB_SIZE_W = 8;

    localparam logic [c_SB_BE_W-1:0] BYTE_EN_ALL = 4'hF;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WAIT_DATA = 4'd1,
        S_REQ       = 4'd2,
        S_BEGIN     = 4'd3,
        S_RDATA     = 4'd4,
        S_WDATA     = 4'd5,
        S_WEND      = 4'd6,
        S_DONE      = 4'd7,
        S_ERR       = 4'd8
    } sb_state_e;

endpackage
`default_nettype wire

// File: rtl/sb_burst_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : sb_burst_master_if
//  Description : Shared OR-bus signal bundle between a burst master and the
//                arbiter/slave side.
//  Ports       : master modport drives request/begin/address-data/byte
//                enables/burst size/direction/end/data valid and receives
//                grant/data/end/data valid/busy/error; slave is the mirror.
//  Revision    : 1.0  initial release
// ============================================================================
interface sb_burst_master_if;
    import sb_burst_master_pkg::*;

    logic                   sb_request_o;
    logic                   sb_grant_i;
    logic                   sb_begin_transaction_o;
    logic [c_SB_DATA_W-1:0] sb_address_data_o;
    logic [c_SB_BE_W-1:0]   sb_byte_enables_o;
    logic [c_SB_SIZE_W-1:0] sb_burst_size_o;
    logic                   sb_read_n_write_o;
    logic                   sb_end_transaction_o;
    logic                   sb_data_valid_o;
    logic [c_SB_DATA_W-1:0] sb_address_data_i;
    logic                   sb_end_transaction_i;
    logic                   sb_data_valid_i;
    logic                   sb_busy_i;
    logic                   sb_error_i;

    modport master (
        output sb_request_o, sb_begin_transaction_o, sb_address_data_o,
               sb_byte_enables_o, sb_burst_size_o, sb_read_n_write_o,
               sb_end_transaction_o, sb_data_valid_o,
        input  sb_grant_i, sb_address_data_i, sb_end_transaction_i,
               sb_data_valid_i, sb_busy_i, sb_error_i
    );

    modport slave (
        input  sb_request_o, sb_begin_transaction_o, sb_address_data_o,
               sb_byte_enables_o, sb_burst_size_o, sb_read_n_write_o,
               sb_end_transaction_o, sb_data_valid_o,
        output sb_grant_i, sb_address_data_i, sb_end_transaction_i,
               sb_data_valid_i, sb_busy_i, sb_error_i
    );

endinterface
`default_nettype wire

// File: rtl/sb_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sb_sync_fifo
//  Description : Single-clock FIFO with fill level and synchronous flush.
//                Push when full and pop when empty are ignored.
//  Ports       : clk, rst_n (async active-low), i_flush, i_push/i_wdata,
//                i_pop, o_rdata (head, valid when o_level != 0), o_level.
//  Revision    : 1.0  initial release
// ============================================================================
module sb_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  wire                          clk,
    input  wire                          rst_n,
    input  wire                          i_flush,
    input  wire                          i_push,
    input  wire  [WIDTH-1:0]             i_wdata,
    input  wire                          i_pop,
    output logic [WIDTH-1:0]             o_rdata,
    output logic [$clog2(DEPTH+1)-1:0]   o_level
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic               w_do_push;
    logic               w_do_pop;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign w_do_push = i_push && (r_level != c_LVL_W'(DEPTH));
    assign w_do_pop  = i_pop  && (r_level != '0);

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            if (w_do_push && !w_do_pop)      r_level <= r_level + 1'b1;
            else if (!w_do_push && w_do_pop) r_level <= r_level - 1'b1;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/sb_burst_master.sv
`default_nettype none
// ============================================================================
//  Module      : sb_burst_master
//  Description : System-bus burst master. Takes one read/write command of up
//                to 65535 words and splits it into arbitrated bursts that
//                never cross a MAX_BURST*4-byte aligned boundary. Data flows
//                through a write FIFO and a read FIFO (sb_sync_fifo).
//  Ports       : sb_clock_i / sb_reset_n_i (async active-low)
//                cmd_*  : command handshake (ready only in IDLE)
//                wr_*   : write-data FIFO push side
//                rd_*   : read-data FIFO pop side
//                done_o : completion pulse, error_o : sticky error
//                sb     : OR-bus master modport (zero when not driving)
//  Options     : `define SB_BURST_MASTER_TIMEOUT_EN enables a watchdog that
//                forces the error path after TIMEOUT_CYCLES idle bus cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module sb_burst_master
    import sb_burst_master_pkg::*;
#(
    parameter int MAX_BURST      = 16,
    parameter int FIFO_DEPTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire          sb_clock_i,
    input  wire          sb_reset_n_i,
    input  wire          cmd_valid_i,
    output logic         cmd_ready_o,
    input  wire          cmd_write_i,
    input  wire  [31:0]  cmd_addr_i,
    input  wire  [15:0]  cmd_count_i,
    input  wire  [31:0]  wr_data_i,
    input  wire          wr_valid_i,
    output logic         wr_ready_o,
    output logic [31:0]  rd_data_o,
    output logic         rd_valid_o,
    input  wire          rd_ready_i,
    output logic         done_o,
    output logic         error_o,
    sb_burst_master_if.master sb
);

    localparam int c_LVL_W = $clog2(FIFO_DEPTH+1);

    sb_state_e    r_state, w_state_nxt;
    logic [31:0]  r_addr;
    logic [15:0]  r_remaining;
    logic         r_write;
    logic         r_error;
    logic [8:0]   r_beat_cnt;

    logic [8:0]   w_word_off, w_to_bound, w_beats, w_rcv;
    logic [c_LVL_W-1:0] w_rd_level, w_wr_level;
    logic [31:0]  w_wr_head;
    logic         w_rd_ok, w_wr_ok;
    logic         w_rd_push, w_wr_pop, w_wr_flush;
    logic         w_beat_inc, w_burst_done, w_timeout;

    // Burst length: remaining words, clipped at the next MAX_BURST-word
    // aligned boundary (which also caps it at MAX_BURST).
    assign w_word_off = 9'((r_addr >> 2) & 32'(MAX_BURST-1));
    assign w_to_bound = 9'(MAX_BURST) - w_word_off;
    assign w_beats    = (r_remaining < 16'(w_to_bound)) ? r_remaining[8:0] : w_to_bound;

    assign w_rd_ok = (32'(FIFO_DEPTH) - 32'(w_rd_level)) >= 32'(w_beats);
    assign w_wr_ok = 32'(w_wr_level) >= 32'(w_beats);

    // Words received in this burst including the one arriving this cycle.
    assign w_rcv = r_beat_cnt + 9'(w_rd_push);

    sb_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk     (sb_clock_i),
        .rst_n   (sb_reset_n_i),
        .i_flush (w_wr_flush),
        .i_push  (wr_valid_i),
        .i_wdata (wr_data_i),
        .i_pop   (w_wr_pop),
        .o_rdata (w_wr_head),
        .o_level (w_wr_level)
    );

    sb_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
        .clk     (sb_clock_i),
        .rst_n   (sb_reset_n_i),
        .i_flush (1'b0),
        .i_push  (w_rd_push),
        .i_wdata (sb.sb_address_data_i),
        .i_pop   (rd_ready_i),
        .o_rdata (rd_data_o),
        .o_level (w_rd_level)
    );

`ifdef SB_BURST_MASTER_TIMEOUT_EN
    localparam int c_WDOG_W = $clog2(TIMEOUT_CYCLES+1);
    logic [c_WDOG_W-1:0] r_wdog;
    logic w_wdog_run, w_wdog_clr;

    assign w_wdog_run = (r_state == S_REQ) || (r_state == S_RDATA) || (r_state == S_WDATA);
    assign w_wdog_clr = ((r_state == S_REQ)   && sb.sb_grant_i) ||
                        ((r_state == S_RDATA) && sb.sb_data_valid_i) ||
                        ((r_state == S_WDATA) && !sb.sb_busy_i);
    assign w_timeout  = w_wdog_run && !w_wdog_clr &&
                        (r_wdog == c_WDOG_W'(TIMEOUT_CYCLES-1));

    always_ff @(posedge sb_clock_i or negedge sb_reset_n_i) begin
        if (!sb_reset_n_i)                   r_wdog <= '0;
        else if (!w_wdog_run || w_wdog_clr)  r_wdog <= '0;
        else                                 r_wdog <= r_wdog + 1'b1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge sb_clock_i or negedge sb_reset_n_i) begin
        if (!sb_reset_n_i) r_state <= S_IDLE;
        else               r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt               = r_state;
        sb.sb_request_o           = 1'b0;
        sb.sb_begin_transaction_o = 1'b0;
        sb.sb_address_data_o      = '0;
        sb.sb_byte_enables_o      = '0;
        sb.sb_burst_size_o        = '0;
        sb.sb_read_n_write_o      = 1'b0;
        sb.sb_end_transaction_o   = 1'b0;
        sb.sb_data_valid_o        = 1'b0;
        w_rd_push                 = 1'b0;
        w_wr_pop                  = 1'b0;
        w_wr_flush                = 1'b0;
        w_beat_inc                = 1'b0;
        w_burst_done              = 1'b0;
        done_o                    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid_i)
                    w_state_nxt = (cmd_count_i == 16'd0) ? S_DONE : S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                if (r_write ? w_wr_ok : w_rd_ok) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                sb.sb_request_o = 1'b1;
                if (w_timeout)           w_state_nxt = S_ERR;
                else if (sb.sb_grant_i)  w_state_nxt = S_BEGIN;
            end
            S_BEGIN: begin
                sb.sb_begin_transaction_o = 1'b1;
                sb.sb_address_data_o      = r_addr;
                sb.sb_byte_enables_o      = BYTE_EN_ALL;
                sb.sb_burst_size_o        = 8'(w_beats - 9'd1);
                sb.sb_read_n_write_o      = !r_write;
                if (sb.sb_error_i) w_state_nxt = S_ERR;
                else               w_state_nxt = r_write ? S_WDATA : S_RDATA;
            end
            S_RDATA: begin
                if (sb.sb_error_i || w_timeout) begin
                    w_state_nxt = S_ERR;
                end else begin
                    // Beats beyond the requested length are dropped.
                    if (sb.sb_data_valid_i && (r_beat_cnt < w_beats)) begin
                        w_rd_push  = 1'b1;
                        w_beat_inc = 1'b1;
                    end
                    if (sb.sb_end_transaction_i) begin
                        if (w_rcv == w_beats) w_burst_done = 1'b1;
                        else                  w_state_nxt  = S_ERR;
                    end
                end
            end
            S_WDATA: begin
                sb.sb_data_valid_o   = 1'b1;
                sb.sb_address_data_o = w_wr_head;
                if (sb.sb_error_i || w_timeout) begin
                    w_state_nxt = S_ERR;
                end else if (!sb.sb_busy_i) begin
                    w_wr_pop   = 1'b1;
                    w_beat_inc = 1'b1;
                    if (r_beat_cnt == w_beats - 9'd1) w_state_nxt = S_WEND;
                end
            end
            S_WEND: begin
                sb.sb_end_transaction_o = 1'b1;
                if (sb.sb_error_i) w_state_nxt  = S_ERR;
                else               w_burst_done = 1'b1;
            end
            S_ERR: begin
                w_wr_flush  = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_burst_done)
            w_state_nxt = (r_remaining == 16'(w_beats)) ? S_DONE : S_WAIT_DATA;
    end

    always_ff @(posedge sb_clock_i or negedge sb_reset_n_i) begin
        if (!sb_reset_n_i) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_write     <= 1'b0;
            r_error     <= 1'b0;
            r_beat_cnt  <= '0;
        end else begin
            if ((r_state == S_IDLE) && cmd_valid_i) begin
                r_addr      <= cmd_addr_i & 32'hFFFF_FFFC;
                r_remaining <= cmd_count_i;
                r_write     <= cmd_write_i;
                r_error     <= 1'b0;
            end
            if (r_state == S_ERR) r_error <= 1'b1;
            if (r_state == S_BEGIN)  r_beat_cnt <= '0;
            else if (w_beat_inc)     r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_burst_done) begin
                r_addr      <= r_addr + {21'd0, w_beats, 2'b00};
                r_remaining <= r_remaining - 16'(w_beats);
            end
        end
    end

    assign cmd_ready_o = (r_state == S_IDLE);
    assign wr_ready_o  = (w_wr_level != c_LVL_W'(FIFO_DEPTH));
    assign rd_valid_o  = (w_rd_level != '0);
    assign error_o     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_sb_burst_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sb_burst_master
//  Description : Directed self-checking bench for sb_burst_master with the
//                default parameters (MAX_BURST=16, FIFO_DEPTH=32).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sb_burst_master;

    logic        sb_clock_i = 1'b0;
    logic        sb_reset_n_i;
    logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [31:0] cmd_addr_i;
    logic [15:0] cmd_count_i;
    logic [31:0] wr_data_i;
    logic        wr_valid_i, wr_ready_o;
    logic [31:0] rd_data_o;
    logic        rd_valid_o, rd_ready_i;
    logic        done_o, error_o;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;

    sb_burst_master_if sb ();

    sb_burst_master dut (
        .sb_clock_i   (sb_clock_i),
        .sb_reset_n_i (sb_reset_n_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_write_i  (cmd_write_i),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_count_i  (cmd_count_i),
        .wr_data_i    (wr_data_i),
        .wr_valid_i   (wr_valid_i),
        .wr_ready_o   (wr_ready_o),
        .rd_data_o    (rd_data_o),
        .rd_valid_o   (rd_valid_o),
        .rd_ready_i   (rd_ready_i),
        .done_o       (done_o),
        .error_o      (error_o),
        .sb           (sb)
    );

    always #5 sb_clock_i = ~sb_clock_i;

    always @(negedge sb_clock_i) if (done_o) n_done++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bus_idle(input string tag);
        check(tag, {sb.sb_request_o, sb.sb_begin_transaction_o, sb.sb_byte_enables_o,
                    sb.sb_burst_size_o, sb.sb_read_n_write_o, sb.sb_end_transaction_o,
                    sb.sb_data_valid_o, sb.sb_address_data_o}, 64'd0);
    endtask

    task automatic check_done(input string tag, input int exp_total);
        #1;
        check(tag, n_done, exp_total);
    endtask

    task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [15:0] cnt);
        @(negedge sb_clock_i);
        check("cmd_ready", cmd_ready_o, 1);
        cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr; cmd_count_i = cnt;
        @(negedge sb_clock_i);
        cmd_valid_i = 1'b0;
    endtask

    task automatic push_wr(input logic [31:0] d);
        @(negedge sb_clock_i);
        check("wr_ready", wr_ready_o, 1);
        wr_data_i = d; wr_valid_i = 1'b1;
        @(negedge sb_clock_i);
        wr_valid_i = 1'b0;
    endtask

    task automatic wait_req(output bit got);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (sb.sb_request_o) begin
                got = 1'b1;
                break;
            end
            @(negedge sb_clock_i);
        end
        check("req_seen", got, 1);
    endtask

    task automatic grant_and_check_begin(input logic [31:0] addr, input int beats, input logic rnw);
        sb.sb_grant_i = 1'b1;
        @(negedge sb_clock_i);
        sb.sb_grant_i = 1'b0;
        check("begin",     sb.sb_begin_transaction_o, 1);
        check("begin_adr", sb.sb_address_data_o, addr);
        check("begin_sz",  sb.sb_burst_size_o, 64'(beats - 1));
        check("begin_rnw", sb.sb_read_n_write_o, rnw);
        check("begin_be",  sb.sb_byte_enables_o, 4'hF);
        check("req_drop",  sb.sb_request_o, 0);
        @(negedge sb_clock_i);
    endtask

    // err_beat < 0: no error. end_gap 0: end with last beat.
    task automatic serve_read(input logic [31:0] addr, input int beats, input logic [31:0] base,
                              input int end_gap, input int err_beat);
        bit got;
        wait_req(got);
        if (!got) return;
        grant_and_check_begin(addr, beats, 1'b1);
        for (int i = 0; i < beats; i++) begin
            sb.sb_data_valid_i   = 1'b1;
            sb.sb_address_data_i = base + 32'(i);
            if (i == err_beat) sb.sb_error_i = 1'b1;
            if (i == beats - 1 && end_gap == 0) sb.sb_end_transaction_i = 1'b1;
            @(negedge sb_clock_i);
            sb.sb_data_valid_i = 1'b0; sb.sb_address_data_i = '0;
            sb.sb_end_transaction_i = 1'b0;
            if (i == err_beat) begin
                sb.sb_error_i = 1'b0;
                return;
            end
        end
        if (end_gap > 0) begin
            repeat (end_gap - 1) @(negedge sb_clock_i);
            sb.sb_end_transaction_i = 1'b1;
            @(negedge sb_clock_i);
            sb.sb_end_transaction_i = 1'b0;
        end
    endtask

    // Busy is raised for one cycle on the first presentation of busy_idx.
    task automatic serve_write(input logic [31:0] addr, input int beats, input logic [31:0] base,
                               input int busy_idx);
        bit got;
        bit stalled = 1'b0;
        int i = 0;
        int guard = 0;
        wait_req(got);
        if (!got) return;
        grant_and_check_begin(addr, beats, 1'b0);
        while (i < beats && guard < 50) begin
            guard++;
            check("wr_dv",   sb.sb_data_valid_o, 1);
            check("wr_data", sb.sb_address_data_o, base + 32'(i));
            if (i == busy_idx && !stalled) begin
                sb.sb_busy_i = 1'b1;
                stalled = 1'b1;
            end else begin
                sb.sb_busy_i = 1'b0;
                i++;
            end
            @(negedge sb_clock_i);
        end
        sb.sb_busy_i = 1'b0;
        check("wr_end",      sb.sb_end_transaction_o, 1);
        check("wr_end_dv",   sb.sb_data_valid_o, 0);
        check("wr_end_data", sb.sb_address_data_o, 0);
        @(negedge sb_clock_i);
    endtask

    task automatic drain_rd(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge sb_clock_i);
            check("rd_valid", rd_valid_o, 1);
            check("rd_data",  rd_data_o, base + 32'(i));
            rd_ready_i = 1'b1;
        end
        @(negedge sb_clock_i);
        rd_ready_i = 1'b0;
        check("rd_empty", rd_valid_o, 0);
    endtask

    initial begin
        bit seen;
        sb_reset_n_i = 1'b0;
        cmd_valid_i = 0; cmd_write_i = 0; cmd_addr_i = '0; cmd_count_i = '0;
        wr_data_i = '0; wr_valid_i = 0; rd_ready_i = 0;
        sb.sb_grant_i = 0; sb.sb_address_data_i = '0; sb.sb_end_transaction_i = 0;
        sb.sb_data_valid_i = 0; sb.sb_busy_i = 0; sb.sb_error_i = 0;
        repeat (3) @(negedge sb_clock_i);
        check("rst_cmd_ready", cmd_ready_o, 1);
        check("rst_wr_ready",  wr_ready_o, 1);
        check("rst_rd_valid",  rd_valid_o, 0);
        check("rst_done",      done_o, 0);
        check("rst_error",     error_o, 0);
        check_bus_idle("rst_bus");
        sb_reset_n_i = 1'b1;

        // Single-word read, end three cycles after the data beat.
        issue_cmd(1'b0, 32'h1000, 16'd1);
        serve_read(32'h1000, 1, 32'hDEADBEEF, 3, -1);
        drain_rd(1, 32'hDEADBEEF);
        check_done("done_rd1", 1);
        check("err_rd1", error_o, 0);
        check_bus_idle("bus_rd1");

        // 40 words: 16/16/8; third burst waits for read-FIFO space.
        issue_cmd(1'b0, 32'h1000, 16'd40);
        serve_read(32'h1000, 16, 32'h100, 0, -1);
        serve_read(32'h1040, 16, 32'h110, 0, -1);
        seen = 1'b0;
        repeat (10) begin
            @(negedge sb_clock_i);
            seen |= sb.sb_request_o;
        end
        check("rd_space_hold", seen, 0);
        drain_rd(32, 32'h100);
        serve_read(32'h1080, 8, 32'h120, 0, -1);
        drain_rd(8, 32'h120);
        check_done("done_rd40", 2);

        // Boundary split at 0x1040.
        issue_cmd(1'b0, 32'h1038, 16'd4);
        serve_read(32'h1038, 2, 32'h200, 0, -1);
        serve_read(32'h1040, 2, 32'h202, 0, -1);
        drain_rd(4, 32'h200);
        check_done("done_rd4", 3);

        // Write with busy stall on beat 2.
        push_wr(32'hA); push_wr(32'hB); push_wr(32'hC);
        issue_cmd(1'b1, 32'h2000, 16'd3);
        serve_write(32'h2000, 3, 32'hA, 1);
        check_done("done_wr3", 4);
        check("err_wr3", error_o, 0);

        // Bus error on beat 3 of an 8-beat read.
        issue_cmd(1'b0, 32'h3000, 16'd8);
        serve_read(32'h3000, 8, 32'h300, 0, 2);
        check_bus_idle("bus_err");
        @(negedge sb_clock_i);
        check("err_done", done_o, 1);
        check("err_flag", error_o, 1);
        drain_rd(2, 32'h300);
        check_done("done_err", 5);

        // Zero-count command; also clears the sticky error.
        issue_cmd(1'b0, 32'h0, 16'd0);
        check("z_done",  done_o, 1);
        check("z_req",   sb.sb_request_o, 0);
        check("z_error", error_o, 0);
        @(negedge sb_clock_i);
        check("z_done_pulse", done_o, 0);
        check("z_ready", cmd_ready_o, 1);
        check_done("done_z", 6);

`ifdef SB_BURST_MASTER_TIMEOUT_EN
        begin
            int req_cycles = 0;
            issue_cmd(1'b0, 32'h4000, 16'd1);
            for (int i = 0; i < 1100; i++) begin
                @(negedge sb_clock_i);
                if (sb.sb_request_o) req_cycles++;
                else if (req_cycles > 0) break;
            end
            check("wdog_cycles", req_cycles, 1024);
            check_bus_idle("wdog_bus");
            @(negedge sb_clock_i);
            check("wdog_err", error_o, 1);
            check_done("done_wdog", 7);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sb_burst_master.md
Name: sb_burst_master

Overview:
Parametrised system-bus burst master for the debug interface; successor of the single-word debug bus-interface unit. Accepts one read or write command of up to 65535 words from the debug clock-domain-crossing logic. Splits the command into arbiter-requested bus bursts, with read and write data buffered in FIFOs. Handles grant, busy, error and end-of-transaction on the shared OR-bus.

Parameters:
MAX_BURST, 16, maximum beats per bus burst (power of 2, 1..256)
FIFO_DEPTH, 32, depth of each data FIFO (power of 2, >= MAX_BURST)
TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature)

Ports:
sb_clock_i  in  1  system clock
sb_reset_n_i  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command strobe
cmd_ready_o  out  1  high only in IDLE
cmd_write_i  in  1  1 = write, 0 = read
cmd_addr_i  in  32  byte address; bits [1:0] ignored
cmd_count_i  in  16  word count
wr_data_i  in  32  write-FIFO data
wr_valid_i  in  1  write-FIFO push
wr_ready_o  out  1  write FIFO not full
rd_data_o  out  32  read-FIFO head
rd_valid_o  out  1  read FIFO not empty
rd_ready_i  in  1  read-FIFO pop
done_o  out  1  one-cycle pulse at command completion
error_o  out  1  sticky; cleared on next accepted command
sb_request_o  out  1  arbiter request
sb_grant_i  in  1  arbiter grant
sb_begin_transaction_o  out  1  burst start
sb_address_data_o  out  32  address on begin, data on write beats, else 0
sb_byte_enables_o  out  4  4'hF on begin, else 0
sb_burst_size_o  out  8  beats-1 on begin, else 0
sb_read_n_write_o  out  1  direction on begin, else 0
sb_end_transaction_o  out  1  write-burst end
sb_data_valid_o  out  1  write beat valid
sb_address_data_i  in  32  bus data
sb_end_transaction_i  in  1  bus end of transaction
sb_data_valid_i  in  1  bus data valid
sb_busy_i  in  1  slave stall
sb_error_i  in  1  bus error

Behaviour:
- Reset: all outputs 0 except cmd_ready_o=1 and wr_ready_o=1; both FIFOs empty. Reset mid-burst drops bus outputs immediately (asynchronous) and abandons the command.
- Bus outputs are all-zero whenever the block is not driving them (OR-bus).
- States: IDLE, WAIT_DATA, REQ, BEGIN, RDATA, WDATA, WEND, DONE, ERR.
- IDLE:
  - On cmd_valid_i, latch addr={cmd_addr_i[31:2],2'b0}, remaining=count, clear error_o.
  - count=0: go to DONE with no bus activity.
- WAIT_DATA: compute beats = min(remaining, MAX_BURST, words left to the next MAX_BURST*4-byte aligned boundary).
  - Read: proceed to REQ only when read-FIFO free space >= beats.
  - Write: proceed to REQ only when the write FIFO holds >= beats words.
- REQ: hold sb_request_o until sb_grant_i is sampled high.
- BEGIN (next cycle): one cycle with sb_begin_transaction_o=1 and request dropped.
- RDATA: push each sb_data_valid_i word into the read FIFO.
  - sb_end_transaction_i after exactly beats words: burst complete.
  - sb_end_transaction_i earlier: go to ERR.
  - Extra beats are discarded.
- WDATA: drive the FIFO head with sb_data_valid_o; pop only when sb_busy_i=0, otherwise hold the same data.
- WEND: one cycle of sb_end_transaction_o after the last beat.
- Burst complete: addr += beats*4 (32-bit wrap); remaining -= beats. remaining=0 goes to DONE, else back to WAIT_DATA.
- sb_error_i in BEGIN, RDATA, WDATA or WEND goes to ERR.
  - ERR: set error_o, flush the write FIFO; the read FIFO keeps received words; then DONE.
- DONE: done_o pulse, return to IDLE.
- FIFO push when full or pop when empty is ignored.

Optional Feature:
SB_BURST_MASTER_TIMEOUT_EN:
- Defined: a counter clears on every grant or bus beat and counts cycles in REQ, RDATA and WDATA.
- Reaching TIMEOUT_CYCLES forces ERR with outputs dropped.
- Undefined: no counter; the block waits indefinitely.

Decomposition:
- Package sb_burst_master_pkg: state enum, bus width constants, BYTE_EN_ALL=4'hF.
- One sub-module, sb_sync_fifo (parametrised width/depth, with level output), instantiated twice.

Test Plan:
- Read 1 word at 0x1000, slave returns 0xDEADBEEF, end transaction 3 cycles later -> burst_size 0, rd_data 0xDEADBEEF, one done_o, error_o=0.
- Read 40 words at 0x1000, MAX_BURST=16 -> bursts of 16/16/8 at 0x1000/0x1040/0x1080 and 40 words in order.
- Read 4 words at 0x1038 -> two bursts of 2 at 0x1038 and 0x1040.
- Write 3 words 0xA,0xB,0xC with sb_busy_i high during beat 2 -> 0xB held 2 cycles, end_transaction after 0xC.
- sb_error_i during beat 3 of an 8-beat read -> 2 words in FIFO, error_o=1, done_o pulses, outputs zero.
- Count 0 -> done_o one cycle after acceptance with no request. With the macro defined, withhold grant -> ERR after 1024 cycles.
